// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - restoring divide sequencer driving the shared ALU (signed mode under DIV_SIGNED_EN)
module alu_div_seq #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic            i_signed,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_alu_a,
   output logic [XLEN-1:0] o_alu_b,
   output logic [3:0]      o_alu_op,
   input  logic [XLEN-1:0] i_alu_data,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_quot,
   output logic [XLEN-1:0] o_rem
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLTU = 4'b0011;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMP   = 3'd1,
      S_SUB   = 3'd2,
      S_DONE  = 3'd3
`ifdef DIV_SIGNED_EN
      ,
      S_NEG_A = 3'd4,
      S_NEG_B = 3'd5,
      S_NEG_Q = 3'd6,
      S_NEG_R = 3'd7
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] dvd_q, dvd_d;       // dividend magnitude
   logic [XLEN-1:0] dsr_q, dsr_d;       // divisor magnitude
   logic [XLEN-1:0] rem_q, rem_d;       // partial remainder
   logic [XLEN-1:0] quot_q, quot_d;     // quotient under construction
   logic [4:0]      idx_q, idx_d;       // current quotient bit
   logic [XLEN-1:0] r_q, r_d;           // shifted remainder carried from CMP to SUB
   logic            ge_q, ge_d;         // shifted remainder >= divisor
   logic            dz_q, dz_d;         // current result came from divide-by-zero
   logic [XLEN-1:0] qout_q, qout_d;
   logic [XLEN-1:0] rout_q, rout_d;
`ifdef DIV_SIGNED_EN
   logic            sgn_q, sgn_d;       // signed request
   logic            sq_q, sq_d;         // quotient must be negated
   logic            sr_q, sr_d;         // remainder must be negated
`else
   logic            unused_signed;
   assign unused_signed = i_signed;
`endif

   logic [XLEN:0]   shifted;
   logic            accept;

   // The divide-by-zero result is produced without taking the ALU, so busy stays low.
   assign o_busy   = (state_q != S_IDLE) && !((state_q == S_DONE) && dz_q);
   assign o_done   = (state_q == S_DONE);
   assign o_quot   = qout_q;
   assign o_rem    = rout_q;
   assign accept   = i_start && !o_busy;
   assign shifted  = {rem_q, dvd_q[idx_q]};

   // Next-state, datapath updates and ALU request for the current state.
   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      idx_d    = idx_q;
      r_d      = r_q;
      ge_d     = ge_q;
      dz_d     = dz_q;
      qout_d   = qout_q;
      rout_d   = rout_q;
`ifdef DIV_SIGNED_EN
      sgn_d    = sgn_q;
      sq_d     = sq_q;
      sr_d     = sr_q;
`endif
      o_alu_a  = '0;
      o_alu_b  = '0;
      o_alu_op = ALU_ADD;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               dvd_d  = i_dividend;
               dsr_d  = i_divisor;
               rem_d  = '0;
               quot_d = '0;
               idx_d  = 5'd31;
               dz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
               sgn_d  = i_signed;
`endif
               if (i_divisor == '0) begin
                  dz_d    = 1'b1;
                  state_d = S_DONE;
                  qout_d  = '1;
                  rout_d  = i_dividend;
               end else begin
`ifdef DIV_SIGNED_EN
                  state_d = i_signed ? S_NEG_A : S_CMP;
`else
                  state_d = S_CMP;
`endif
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_CMP: begin
            o_alu_a  = shifted[XLEN-1:0];
            o_alu_b  = dsr_q;
            o_alu_op = ALU_SLTU;
            r_d      = shifted[XLEN-1:0];
            ge_d     = shifted[XLEN] | ~i_alu_data[0];
            state_d  = S_SUB;
         end
         S_SUB: begin
            o_alu_a        = r_q;
            o_alu_b        = dsr_q;
            o_alu_op       = ALU_SUB;
            rem_d          = ge_q ? i_alu_data : r_q;
            quot_d[idx_q]  = ge_q;
            if (idx_q == 5'd0) begin
`ifdef DIV_SIGNED_EN
               if (sgn_q) begin
                  state_d = S_NEG_Q;
               end else
`endif
               begin
                  state_d = S_DONE;
                  qout_d  = quot_d;
                  rout_d  = rem_d;
               end
            end else begin
               idx_d   = idx_q - 5'd1;
               state_d = S_CMP;
            end
         end
`ifdef DIV_SIGNED_EN
         S_NEG_A: begin
            o_alu_b  = dvd_q;
            o_alu_op = ALU_SUB;
            sr_d     = dvd_q[XLEN-1];
            if (dvd_q[XLEN-1]) dvd_d = i_alu_data;
            state_d  = S_NEG_B;
         end
         S_NEG_B: begin
            o_alu_b  = dsr_q;
            o_alu_op = ALU_SUB;
            sq_d     = sr_q ^ dsr_q[XLEN-1];
            if (dsr_q[XLEN-1]) dsr_d = i_alu_data;
            state_d  = S_CMP;
         end
         S_NEG_Q: begin
            o_alu_b  = quot_q;
            o_alu_op = ALU_SUB;
            if (sq_q) quot_d = i_alu_data;
            state_d  = S_NEG_R;
         end
         S_NEG_R: begin
            o_alu_b  = rem_q;
            o_alu_op = ALU_SUB;
            if (sr_q) rem_d = i_alu_data;
            state_d  = S_DONE;
            qout_d   = quot_q;
            rout_d   = rem_d;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         idx_q   <= '0;
         r_q     <= '0;
         ge_q    <= 1'b0;
         dz_q    <= 1'b0;
         qout_q  <= '0;
         rout_q  <= '0;
`ifdef DIV_SIGNED_EN
         sgn_q   <= 1'b0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         idx_q   <= idx_d;
         r_q     <= r_d;
         ge_q    <= ge_d;
         dz_q    <= dz_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
`ifdef DIV_SIGNED_EN
         sgn_q   <= sgn_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - scoreboard bench for alu_div_seq with a behavioural divide model
module tb_alu_div_seq;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_signed = 1'b0;
   logic [31:0] i_dividend = '0;
   logic [31:0] i_divisor = '0;
   logic [31:0] o_alu_a, o_alu_b, i_alu_data;
   logic [3:0]  o_alu_op;
   logic        o_busy, o_done;
   logic [31:0] o_quot, o_rem;

   typedef struct {
      logic [31:0] quot;
      logic [31:0] rem;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;

   alu_div_seq #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_signed(i_signed),
      .i_dividend(i_dividend), .i_divisor(i_divisor),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_data(i_alu_data),
      .o_busy(o_busy), .o_done(o_done), .o_quot(o_quot), .o_rem(o_rem)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Shared execute-stage ALU, combinational
   always_comb begin
      i_alu_data = '0;
      case (o_alu_op)
         4'b0000: i_alu_data = o_alu_a + o_alu_b;
         4'b0001: i_alu_data = o_alu_a - o_alu_b;
         4'b0011: i_alu_data = {31'b0, o_alu_a < o_alu_b};
         default: i_alu_data = '0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // RV32M reference: result and latency in cycles from the start cycle
   task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
      logic se;
      int   sa, sb;
`ifdef DIV_SIGNED_EN
      se = sgn;
`else
      se = 1'b0 & sgn;
`endif
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (!se) begin
         q = a / b; r = a % b; lat = 65;
      end else begin
         lat = 69;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
         end else begin
            q = sa / sb; r = sa % sb;
         end
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle 1
   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   lat;
      model(sgn, a, b, e.quot, e.rem, lat);
      e.due = cyc + lat;
      exp_q.push_back(e);
      i_signed = sgn; i_dividend = a; i_divisor = b; i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   // Returns at the negedge of the cycle following o_done
   task automatic wait_done();
      bit got = 0;
      for (int i = 0; i < 200; i++) begin
         if (o_done) begin got = 1; break; end
         @(negedge i_clk);
      end
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: got no o_done want o_done within 200 cycles (cycle %0d)", cyc);
      end
      @(negedge i_clk);
   endtask

   // Monitor: every o_done pulse is matched against the oldest expectation
   always @(negedge i_clk) begin
      if (!i_reset && o_done) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_unexpected: got o_done=1 want no pulse (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("quot", o_quot, mon_e.quot);
            check("rem", o_rem, mon_e.rem);
            check("done_cycle", cyc, mon_e.due);
         end
      end
   end

   initial begin
      int bad;
      logic [31:0] a, b;
      repeat (3) @(negedge i_clk);
      check("rst_outs", {o_busy, o_done, o_alu_op}, 32'd0);
      check("rst_alu_ab", o_alu_a | o_alu_b, 32'd0);
      check("rst_quot_rem", o_quot | o_rem, 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);

      // DIVU 100/7: op sequence, ignored start at cycle 10, busy window
      start_op(1'b0, 32'd100, 32'd7);
      bad = 0;
      for (int k = 1; k <= 64; k++) begin
         if (o_alu_op !== ((k % 2 == 1) ? 4'b0011 : 4'b0001) || o_busy !== 1'b1) bad++;
         if (k == 10) begin i_start = 1'b1; i_dividend = 32'd50; i_divisor = 32'd5; end
         if (k == 11) i_start = 1'b0;
         @(negedge i_clk);
      end
      check("alu_op_seq_bad_cycles", bad, 32'd0);
      check("busy_c65", {31'b0, o_busy}, 32'd1);
      @(negedge i_clk);
      check("busy_c66", {31'b0, o_busy}, 32'd0);

      // Start in cycle 66 plus carry-bit case
      start_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
      wait_done();

      // Divide by zero
      start_op(1'b0, 32'd5, 32'd0);
      check("dz_busy", {31'b0, o_busy}, 32'd0);
      wait_done();
      check("dz_busy_after", {31'b0, o_busy}, 32'd0);

`ifdef DIV_SIGNED_EN
      start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done();
      start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();
`endif

      // Reset in cycle 30 of a division
      start_op(1'b0, 32'd1000, 32'd3);
      repeat (29) @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      exp_q.delete();
      check("midrst_outs", {o_busy, o_done, o_alu_op}, 32'd0);
      check("midrst_alu_ab", o_alu_a | o_alu_b, 32'd0);
      check("midrst_quot_rem", o_quot | o_rem, 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      start_op(1'b0, 32'd9, 32'd3);
      wait_done();

      // Randomized requests
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 20);
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         start_op(1'($urandom_range(0, 1)), a, b);
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end

      repeat (3) @(negedge i_clk);
      check("pending_left", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
